// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port synchronous data memory between two requesters
// (port 0 = CPU, port 1 = auxiliary master) with round-robin arbitration
// and a req/ack handshake.
//
// Ports
//   clk, rst_n                : clock, synchronous active-low reset
//   reqK, weK, addrK, wdataK  : port K request, write enable, address, data
//   ackK                      : port K one-cycle completion pulse
//   rdataK                    : port K read data, held until next port K read
//   mem_we, mem_addr, mem_wdata : memory command (address/data held between accesses)
//   mem_rdata                 : memory read data, valid one cycle after address
//   busy                      : arbiter not idle
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  ack0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE0,
      ISSUE1,
      RESP0,
      RESP1
   } state_t;

   state_t                  state, state_nxt;
   logic                    last;       // port served most recently
   logic                    we_q;       // write enable of the access in flight
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   rdata0_q;
   logic [DATA_WIDTH-1:0]   rdata1_q;
   logic                    elig0, elig1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         last     <= 1'b1;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ISSUE0: begin
               last    <= 1'b0;
               we_q    <= we0;
               addr_q  <= addr0;
               wdata_q <= wdata0;
            end
            ISSUE1: begin
               last    <= 1'b1;
               we_q    <= we1;
               addr_q  <= addr1;
               wdata_q <= wdata1;
            end
            RESP0: if (!we_q) rdata0_q <= mem_rdata;
            RESP1: if (!we_q) rdata1_q <= mem_rdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      elig0     = req0;
      elig1     = req1;
      state_nxt = state;
      mem_we    = 1'b0;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      ack0      = 1'b0;
      ack1      = 1'b0;
      rdata0    = rdata0_q;
      rdata1    = rdata1_q;
      busy      = (state != IDLE);

      // the port just acknowledged still shows req this cycle; ignore it
      if (state == RESP0) elig0 = 1'b0;
      if (state == RESP1) elig1 = 1'b0;

      case (state)
         IDLE, RESP0, RESP1: begin
            if (elig0 && elig1)
               state_nxt = last ? ISSUE0 : ISSUE1;
            else if (elig0)
               state_nxt = ISSUE0;
            else if (elig1)
               state_nxt = ISSUE1;
            else
               state_nxt = IDLE;
         end
         ISSUE0: begin
            state_nxt = RESP0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_we    = we0;
         end
         ISSUE1: begin
            state_nxt = RESP1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_we    = we1;
         end
         default: state_nxt = IDLE;
      endcase

      if (state == RESP0) begin
         ack0 = 1'b1;
         if (!we_q) rdata0 = mem_rdata;
      end
      if (state == RESP1) begin
         ack1 = 1'b1;
         if (!we_q) rdata1 = mem_rdata;
      end

      // a reset arriving during ISSUE must not let the write commit at that edge
      if (!rst_n) mem_we = 1'b0;
   end

endmodule
